memory_cycle: RTL and testbench

Pipeline MEM stage placed directly after the execute stage. Takes the EX/MEM register outputs, performs loads and stores against a Hamming-protected data memory, and drives the MEM/WB pipeline registers consumed by writeback. Single-bit errors on loads are corrected, counted and scrubbed back to the array. Uncorrectable errors are flagged, and the address of the first one is captured.

---
 rtl/memory_cycle_pkg.sv | 76 +++++++
 rtl/memory_cycle_hamming_decoder.sv | 48 ++++
 rtl/memory_cycle.sv | 162 ++++++++++++++++
 tb/tb_memory_cycle.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/memory_cycle_pkg.sv
// Shared ECC definitions for the MEM stage: codeword width, parity positions,
// Hamming encode / syndrome helpers. Build macro ECC_DED_EN selects 39-bit
// SEC-DED (overall parity in bit 38); undefined gives 38-bit SEC only.
package memory_cycle_pkg;

`ifdef ECC_DED_EN
    localparam int CW_W = 39;
`else
    localparam int CW_W = 38;
`endif

    // Hamming positions 1..38 live at codeword bit p-1
    localparam int HAM_W = 38;
    localparam int NPAR  = 6;
    localparam int PAR_POS [NPAR] = '{1, 2, 4, 8, 16, 32};

    typedef logic [CW_W-1:0] cw_t;

    function automatic logic is_par_pos(input int p);
        logic r;
        r = 1'b0;
        for (int k = 0; k < NPAR; k++) begin
            if (p == PAR_POS[k]) r = 1'b1;
        end
        return r;
    endfunction

    // XOR of the positions of every set bit in the Hamming field
    function automatic logic [5:0] ecc_syndrome(input logic [HAM_W-1:0] h);
        logic [5:0] s;
        s = '0;
        for (int p = 1; p <= HAM_W; p++) begin
            if (h[p-1]) s = s ^ 6'(p);
        end
        return s;
    endfunction

    // Data bits fill the non-parity positions in ascending order
    function automatic logic [31:0] ecc_extract(input logic [HAM_W-1:0] h);
        logic [31:0] d;
        int          j;
        d = '0;
        j = 0;
        for (int p = 1; p <= HAM_W; p++) begin
            if (!is_par_pos(p)) begin
                d[j] = h[p-1];
                j++;
            end
        end
        return d;
    endfunction

    // Parity bits are chosen so the syndrome of the finished word is zero
    function automatic cw_t ecc_encode(input logic [31:0] data);
        cw_t        cw;
        logic [5:0] s;
        int         j;
        cw = '0;
        j  = 0;
        for (int p = 1; p <= HAM_W; p++) begin
            if (!is_par_pos(p)) begin
                cw[p-1] = data[j];
                j++;
            end
        end
        s = ecc_syndrome(cw[HAM_W-1:0]);
        for (int k = 0; k < NPAR; k++) begin
            cw[PAR_POS[k]-1] = s[k];
        end
`ifdef ECC_DED_EN
        cw[CW_W-1] = ^cw[HAM_W-1:0];
`endif
        return cw;
    endfunction

endpackage

// File: rtl/memory_cycle_hamming_decoder.sv
// Combinational Hamming decoder: corrects single-bit errors, flags the rest.
// With ECC_DED_EN the overall parity bit separates single from double errors.
import memory_cycle_pkg::*;

module hamming_decoder (
    input  logic [CW_W-1:0] cw_i,
    output logic [31:0]     data_o,
    output logic            corr_o,
    output logic            uncorr_o
);

    logic [5:0]       syn;
    logic [HAM_W-1:0] fixed;
    logic             flip_ok;

    // Syndrome lookup, single-bit flip and data extraction
    always_comb begin
        syn      = ecc_syndrome(cw_i[HAM_W-1:0]);
        fixed    = cw_i[HAM_W-1:0];
        corr_o   = 1'b0;
        uncorr_o = 1'b0;
        flip_ok  = (syn != 6'd0) && (syn <= 6'(HAM_W));
`ifdef ECC_DED_EN
        if (^cw_i) begin
            // Odd overall parity: one bit flipped; syndrome 0 means bit 38 itself
            if (syn == 6'd0) begin
                corr_o = 1'b1;
            end else if (flip_ok) begin
                fixed[syn - 6'd1] = ~fixed[syn - 6'd1];
                corr_o = 1'b1;
            end else begin
                uncorr_o = 1'b1;
            end
        end else if (syn != 6'd0) begin
            uncorr_o = 1'b1;
        end
`else
        if (flip_ok) begin
            fixed[syn - 6'd1] = ~fixed[syn - 6'd1];
            corr_o = 1'b1;
        end else if (syn != 6'd0) begin
            uncorr_o = 1'b1;
        end
`endif
        data_o = ecc_extract(fixed);
    end

endmodule

// File: rtl/memory_cycle.sv
// MEM pipeline stage: Hamming-protected data memory, load correction with
// scrub-on-read, corrected-error counter, first-fatal-address capture and
// the MEM/WB register set. ECC_DED_EN selects SEC-DED instead of SEC.
import memory_cycle_pkg::*;

module memory_cycle #(
    parameter int DEPTH = 1024,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWriteM,
    input  logic             MemWriteM,
    input  logic             ResultSrcM,
    input  logic [4:0]       RD_M,
    input  logic [31:0]      PCPlus4M,
    input  logic [31:0]      WriteDataM,
    input  logic [31:0]      ALU_ResultM,
    input  logic             inj_en,
    input  logic [38:0]      inj_mask,
    output logic             RegWriteW,
    output logic             ResultSrcW,
    output logic [4:0]       RD_W,
    output logic [31:0]      PCPlus4W,
    output logic [31:0]      ALU_ResultW,
    output logic [31:0]      ReadDataW,
    output logic             ecc_corr_W,
    output logic             ecc_uncorr_W,
    output logic [CNT_W-1:0] ecc_corr_cnt,
    output logic             ecc_fatal,
    output logic [31:0]      ecc_fatal_addr
);

    localparam int ADDR_W = $clog2(DEPTH);

    cw_t               mem_q [DEPTH];
    logic [ADDR_W-1:0] idx;
    cw_t               rd_cw;
    cw_t               inj_cw;
    logic [31:0]       dec_data;
    logic              dec_corr;
    logic              dec_uncorr;
    logic              is_load;
    logic              mem_we;
    cw_t               mem_wdata;

    logic              reg_write_w_q, reg_write_w_d;
    logic              result_src_w_q, result_src_w_d;
    logic [4:0]        rd_w_q, rd_w_d;
    logic [31:0]       pc_plus4_w_q, pc_plus4_w_d;
    logic [31:0]       alu_result_w_q, alu_result_w_d;
    logic [31:0]       read_data_w_q, read_data_w_d;
    logic              corr_w_q, corr_w_d;
    logic              uncorr_w_q, uncorr_w_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              fatal_q, fatal_d;
    logic [31:0]       fatal_addr_q, fatal_addr_d;

    assign idx     = ALU_ResultM[ADDR_W+1:2];
    assign rd_cw   = mem_q[idx];
    assign is_load = ResultSrcM & ~MemWriteM;

`ifdef ECC_DED_EN
    assign inj_cw = inj_mask;
`else
    // Bit 38 has no storage in the SEC-only array
    logic unused_inj_msb;
    assign inj_cw         = inj_mask[CW_W-1:0];
    assign unused_inj_msb = inj_mask[38];
`endif

    hamming_decoder u_dec (
        .cw_i     (rd_cw),
        .data_o   (dec_data),
        .corr_o   (dec_corr),
        .uncorr_o (dec_uncorr)
    );

    // Single write port: stores win, otherwise scrub a corrected load
    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (MemWriteM) begin
            mem_we    = 1'b1;
            mem_wdata = ecc_encode(WriteDataM) ^ (inj_en ? inj_cw : '0);
        end else if (is_load && dec_corr) begin
            mem_we    = 1'b1;
            mem_wdata = ecc_encode(dec_data);
        end
    end

    // Array write; reset clears every word to the all-zero codeword (encodes 0)
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[idx] <= mem_wdata;
        end
    end

    // MEM/WB next values and error bookkeeping
    always_comb begin
        reg_write_w_d  = RegWriteM;
        result_src_w_d = ResultSrcM;
        rd_w_d         = RD_M;
        pc_plus4_w_d   = PCPlus4M;
        alu_result_w_d = ALU_ResultM;
        read_data_w_d  = dec_data;
        corr_w_d       = is_load & dec_corr;
        uncorr_w_d     = is_load & dec_uncorr;
        cnt_d          = cnt_q;
        fatal_d        = fatal_q;
        fatal_addr_d   = fatal_addr_q;
        if (corr_w_d && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
        if (uncorr_w_d && !fatal_q) begin
            fatal_d      = 1'b1;
            fatal_addr_d = ALU_ResultM;
        end
    end

    // MEM/WB and status registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            reg_write_w_q  <= 1'b0;
            result_src_w_q <= 1'b0;
            rd_w_q         <= '0;
            pc_plus4_w_q   <= '0;
            alu_result_w_q <= '0;
            read_data_w_q  <= '0;
            corr_w_q       <= 1'b0;
            uncorr_w_q     <= 1'b0;
            cnt_q          <= '0;
            fatal_q        <= 1'b0;
            fatal_addr_q   <= '0;
        end else begin
            reg_write_w_q  <= reg_write_w_d;
            result_src_w_q <= result_src_w_d;
            rd_w_q         <= rd_w_d;
            pc_plus4_w_q   <= pc_plus4_w_d;
            alu_result_w_q <= alu_result_w_d;
            read_data_w_q  <= read_data_w_d;
            corr_w_q       <= corr_w_d;
            uncorr_w_q     <= uncorr_w_d;
            cnt_q          <= cnt_d;
            fatal_q        <= fatal_d;
            fatal_addr_q   <= fatal_addr_d;
        end
    end

    assign RegWriteW      = reg_write_w_q;
    assign ResultSrcW     = result_src_w_q;
    assign RD_W           = rd_w_q;
    assign PCPlus4W       = pc_plus4_w_q;
    assign ALU_ResultW    = alu_result_w_q;
    assign ReadDataW      = read_data_w_q;
    assign ecc_corr_W     = corr_w_q;
    assign ecc_uncorr_W   = uncorr_w_q;
    assign ecc_corr_cnt   = cnt_q;
    assign ecc_fatal      = fatal_q;
    assign ecc_fatal_addr = fatal_addr_q;

endmodule

// File: tb/tb_memory_cycle.sv
// Scoreboard bench for memory_cycle. A small counter width is used so that
// saturation is reachable. Honours ECC_DED_EN for the DED-only cases.
module tb_memory_cycle;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]       RD_M;
    logic [31:0]      PCPlus4M, WriteDataM, ALU_ResultM;
    logic             inj_en;
    logic [38:0]      inj_mask;
    logic             RegWriteW, ResultSrcW;
    logic [4:0]       RD_W;
    logic [31:0]      PCPlus4W, ALU_ResultW, ReadDataW;
    logic             ecc_corr_W, ecc_uncorr_W;
    logic [CNT_W-1:0] ecc_corr_cnt;
    logic             ecc_fatal;
    logic [31:0]      ecc_fatal_addr;

    memory_cycle #(.DEPTH(1024), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .RegWriteM      (RegWriteM),
        .MemWriteM      (MemWriteM),
        .ResultSrcM     (ResultSrcM),
        .RD_M           (RD_M),
        .PCPlus4M       (PCPlus4M),
        .WriteDataM     (WriteDataM),
        .ALU_ResultM    (ALU_ResultM),
        .inj_en         (inj_en),
        .inj_mask       (inj_mask),
        .RegWriteW      (RegWriteW),
        .ResultSrcW     (ResultSrcW),
        .RD_W           (RD_W),
        .PCPlus4W       (PCPlus4W),
        .ALU_ResultW    (ALU_ResultW),
        .ReadDataW      (ReadDataW),
        .ecc_corr_W     (ecc_corr_W),
        .ecc_uncorr_W   (ecc_uncorr_W),
        .ecc_corr_cnt   (ecc_corr_cnt),
        .ecc_fatal      (ecc_fatal),
        .ecc_fatal_addr (ecc_fatal_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic        rs;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic [31:0] alu;
        logic        chk_rd;
        logic [31:0] rdata;
        logic        corr;
        logic        uncorr;
        logic [31:0] cnt;
        logic        fatal;
        logic [31:0] faddr;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          m_cnt   = 0;
    logic        m_fatal = 1'b0;
    logic [31:0] m_faddr = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk("RegWriteW",      32'(RegWriteW),      32'(e.rw));
        chk("ResultSrcW",     32'(ResultSrcW),     32'(e.rs));
        chk("RD_W",           32'(RD_W),           32'(e.rd));
        chk("PCPlus4W",       PCPlus4W,            e.pc4);
        chk("ALU_ResultW",    ALU_ResultW,         e.alu);
        if (e.chk_rd) chk("ReadDataW", ReadDataW,  e.rdata);
        chk("ecc_corr_W",     32'(ecc_corr_W),     32'(e.corr));
        chk("ecc_uncorr_W",   32'(ecc_uncorr_W),   32'(e.uncorr));
        chk("ecc_corr_cnt",   32'(ecc_corr_cnt),   e.cnt);
        chk("ecc_fatal",      32'(ecc_fatal),      32'(e.fatal));
        chk("ecc_fatal_addr", ecc_fatal_addr,      e.faddr);
    endtask

    // One pipeline cycle: drive M-side, push expectation, clock, compare W-side
    task automatic cyc(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                       input logic [31:0] pc4, input logic [31:0] wd, input logic [31:0] alu,
                       input logic inj, input logic [38:0] mask,
                       input logic [31:0] exp_rd, input logic exp_corr, input logic exp_uncorr);
        exp_t e;
        logic ld;
        RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; RD_M = rd;
        PCPlus4M = pc4; WriteDataM = wd; ALU_ResultM = alu; inj_en = inj; inj_mask = mask;
        ld = rs & ~mw;
        if (ld && exp_corr && m_cnt < CNT_MAX) m_cnt++;
        if (ld && exp_uncorr && !m_fatal) begin
            m_fatal = 1'b1;
            m_faddr = alu;
        end
        e.rw = rw; e.rs = rs; e.rd = rd; e.pc4 = pc4; e.alu = alu;
        e.chk_rd = ld; e.rdata = exp_rd;
        e.corr = ld & exp_corr; e.uncorr = ld & exp_uncorr;
        e.cnt = 32'(m_cnt); e.fatal = m_fatal; e.faddr = m_faddr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [38:0] mask);
        cyc(1'b0, 1'b1, 1'b0, 5'd0, addr + 32'h1000, data, addr, mask != '0, mask,
            32'h0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] exp_data,
                        input logic corr, input logic uncorr);
        cyc(1'b1, 1'b0, 1'b1, 5'd9, addr + 32'h2000, 32'hFFFF_FFFF, addr, 1'b0, '0,
            exp_data, corr, uncorr);
    endtask

    // Synchronous reset with junk inputs that must be ignored
    task automatic do_reset();
        exp_t e;
        rst = 1'b0;
        RegWriteM = 1'b1; MemWriteM = 1'b1; ResultSrcM = 1'b1; RD_M = 5'd31;
        PCPlus4M = $urandom; WriteDataM = $urandom; ALU_ResultM = 32'h80;
        inj_en = 1'b1; inj_mask = 39'h7F_FFFF_FFFF;
        m_cnt = 0; m_fatal = 1'b0; m_faddr = '0;
        e.rw = 0; e.rs = 0; e.rd = 0; e.pc4 = 0; e.alu = 0; e.chk_rd = 1'b1; e.rdata = 0;
        e.corr = 0; e.uncorr = 0; e.cnt = 0; e.fatal = 0; e.faddr = 0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
        rst = 1'b1;
    endtask

    initial begin
        logic [38:0] mask_a;
        logic [31:0] xr_a;
        logic [38:0] m;
        logic [31:0] d;
        rst = 1'b0;
        RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0; RD_M = 0;
        PCPlus4M = 0; WriteDataM = 0; ALU_ResultM = 0; inj_en = 0; inj_mask = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Clean store then load next cycle
        store(32'h40, 32'hDEADBEEF, '0);
        load(32'h40, 32'hDEADBEEF, 1'b0, 1'b0);

        // Pass-through with no memory op
        cyc(1'b1, 1'b0, 1'b0, 5'd7, 32'h24, 32'h0, 32'h55, 1'b0, '0, 32'h0, 1'b0, 1'b0);

        // Single-bit error corrected, then scrubbed
        store(32'h80, 32'h12345678, 39'h20);
        load(32'h80, 32'h12345678, 1'b1, 1'b0);
        load(32'h80, 32'h12345678, 1'b0, 1'b0);

        // Address wrap and ignored low bits
        store(32'h1000, 32'hA5A5A5A5, '0);
        load(32'h0, 32'hA5A5A5A5, 1'b0, 1'b0);
        store(32'h3, 32'h0BADF00D, '0);
        load(32'h0, 32'h0BADF00D, 1'b0, 1'b0);

        // Uncorrectable loads; raw data returned, first address captured
`ifdef ECC_DED_EN
        mask_a = (39'd1 << 3) | (39'd1 << 10);   // positions 4,11: data bit 6
        xr_a   = 32'h40;
`else
        mask_a = (39'd1 << 31) | (39'd1 << 6);   // positions 32,7: syndrome 39, data bit 3
        xr_a   = 32'h8;
`endif
        store(32'h100, 32'hCAFE0001, mask_a);
        load(32'h100, 32'hCAFE0001 ^ xr_a, 1'b0, 1'b1);
        store(32'h104, 32'h5555AAAA, (39'd1 << 31) | (39'd1 << 6));
        load(32'h104, 32'h5555AAAA ^ 32'h8, 1'b0, 1'b1);
        // Clean overwrite clears the injected error
        store(32'h104, 32'h5555AAAA, '0);
        load(32'h104, 32'h5555AAAA, 1'b0, 1'b0);

`ifdef ECC_DED_EN
        // Overall-parity bit alone: corrected, data unchanged
        store(32'h200, 32'h00C0FFEE, 39'd1 << 38);
        load(32'h200, 32'h00C0FFEE, 1'b1, 1'b0);
        load(32'h200, 32'h00C0FFEE, 1'b0, 1'b0);
`endif

        // Random single-bit errors drive the counter into saturation
        for (int i = 0; i < CNT_MAX + 3; i++) begin
            m = 39'd1 << $urandom_range(0, 37);
            d = $urandom;
            store(32'h300 + 32'(i) * 4, d, m);
            load(32'h300 + 32'(i) * 4, d, 1'b1, 1'b0);
        end

        // Mid-stream reset after a corrected load
        store(32'h80, 32'h12345678, 39'h20);
        load(32'h80, 32'h12345678, 1'b1, 1'b0);
        do_reset();
        load(32'h80, 32'h0, 1'b0, 1'b0);
        load(32'h40, 32'h0, 1'b0, 1'b0);

        if (sb.size() != 0) chk("sb_leftover", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
